// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types: response codes and the master FSM state encoding.
package axi_lite_pkg;
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axil_resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    RSP
  } axil_master_state_t;
endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: one single-beat command in flight, turned into AW/W/B or AR/R traffic.
// Every AXI and response output comes straight from a flop.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int AXIL_ADDR_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [AXIL_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXIL_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [AXIL_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_write,
  output logic [AXIL_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                   rsp_resp,
  output logic                         awvalid,
  input  logic                         awready,
  output logic [AXIL_ADDR_WIDTH-1:0]   awaddr,
  output logic                         wvalid,
  input  logic                         wready,
  output logic [AXIL_DATA_WIDTH-1:0]   wdata,
  output logic [AXIL_DATA_WIDTH/8-1:0] wstrb,
  input  logic                         bvalid,
  output logic                         bready,
  input  logic [1:0]                   bresp,
  output logic                         arvalid,
  input  logic                         arready,
  output logic [AXIL_ADDR_WIDTH-1:0]   araddr,
  input  logic                         rvalid,
  output logic                         rready,
  input  logic [AXIL_DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]                   rresp
);
  localparam int SW = AXIL_DATA_WIDTH / 8;

  axil_master_state_t state_q, state_d;
  logic                       alive_q, alive_d;
  logic                       aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [AXIL_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXIL_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]              wstrb_q, wstrb_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d, rsp_valid_q, rsp_valid_d;
  logic                       rsp_write_q, rsp_write_d;
  logic [AXIL_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                 rsp_resp_q, rsp_resp_d;

  // alive_q holds cmd_ready low while reset is asserted even though state is already IDLE
  assign cmd_ready = (state_q == IDLE) && alive_q;
  assign awvalid   = awvalid_q;
  assign awaddr    = addr_q;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign araddr    = addr_q;
  assign rready    = rready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

  always_comb begin
    state_d     = state_q;
    alive_d     = 1'b1;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    unique case (state_q)
      IDLE: if (cmd_valid && alive_q) begin
        addr_d  = cmd_addr;
        wdata_d = cmd_wdata;
        wstrb_d = cmd_wstrb;
        if (cmd_write) begin
          state_d   = WR_REQ;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          state_d   = RD_REQ;
          arvalid_d = 1'b1;
        end
      end
      WR_REQ: begin
        // AW and W complete independently; B is awaited only once both have gone
        if (awvalid_q && awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: if (bvalid && bready_q) begin
        bready_d    = 1'b0;
        rsp_resp_d  = bresp;
        rsp_write_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_valid_d = 1'b1;
        state_d     = RSP;
      end
      RD_REQ: if (arvalid_q && arready) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = RD_RESP;
      end
      RD_RESP: if (rvalid && rready_q) begin
        rready_d    = 1'b0;
        rsp_rdata_d = rdata;
        rsp_resp_d  = rresp;
        rsp_write_d = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = RSP;
      end
      RSP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      alive_q     <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      alive_q     <= alive_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  a_aw_hold: assert property (@(posedge clk) disable iff (reset)
    awvalid && !awready |=> awvalid && $stable(awaddr));
  a_w_hold: assert property (@(posedge clk) disable iff (reset)
    wvalid && !wready |=> wvalid && $stable(wdata) && $stable(wstrb));
  a_ar_hold: assert property (@(posedge clk) disable iff (reset)
    arvalid && !arready |=> arvalid && $stable(araddr));
endmodule
